// File: rtl/gfx_renderer.sv
// gfx_renderer
// Pixel-serialising stage between the graphics fetch sequencer and the line
// buffer write port. Each accepted start delivers one 8-pixel, 4bpp pattern
// group. The stage writes one pixel per clock and resolves tile-vs-sprite and
// sprite-vs-sprite priority with two per-column masks.
//
// Ports:
//   clk             system clock
//   reset           synchronous, active-low reset
//   render_idx      line-buffer column of pixel 0 of the group
//   render_data     8 pixels x 4 bits, pixel 0 = [31:28], pixel 7 = [3:0]
//   render_start    single-cycle strobe; all group inputs are sampled with it
//   is_sprite       1 = sprite group, 0 = tile/bitmap group
//   hflip           emit pixels 7..0 instead of 0..7
//   palette         palette select for the group
//   render_priority tile: priority over sprites; sprite: in front of priority tiles
//   last_pixel      high while the 8th pixel of the group is on the outputs
//   busy            high while the group's pixels are on the outputs
//   wridx           line-buffer write column
//   wrdata          {palette, color}
//   wren            line-buffer write enable
module gfx_renderer #(
  parameter int VISIBLE_W = 320
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  render_idx,
  input  logic [31:0] render_data,
  input  logic        render_start,
  input  logic        is_sprite,
  input  logic        hflip,
  input  logic [1:0]  palette,
  input  logic        render_priority,
  output logic        last_pixel,
  output logic        busy,
  output logic [8:0]  wridx,
  output logic [5:0]  wrdata,
  output logic        wren
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;
  localparam logic [9:0] VIS_W   = VISIBLE_W[9:0];

  logic [0:0]  state_reg;
  logic [2:0]  k_reg;
  logic [8:0]  idx_reg;
  logic [31:0] data_reg;
  logic        sprite_reg;
  logic        hflip_reg;
  logic [1:0]  pal_reg;
  logic        prio_reg;

  logic [8:0]  wridx_reg;
  logic [5:0]  wrdata_reg;
  logic        wren_reg;

  // Per-column masks; deliberately not reset, tile passes reinitialise them.
  logic [VISIBLE_W-1:0] tprio;
  logic [VISIBLE_W-1:0] socc;

  logic        emitting;
  logic        at_last;
  logic        accept;
  logic        advance;
  logic        fire;

  logic [8:0]  src_idx;
  logic [31:0] src_data;
  logic        src_sprite;
  logic        src_hflip;
  logic [1:0]  src_pal;
  logic        src_prio;
  logic [2:0]  src_k;
  logic [2:0]  nib_sel;
  logic [3:0]  color;
  logic [8:0]  col;
  logic        visible;
  logic        tprio_at;
  logic        socc_at;
  logic        write;

  assign emitting = (state_reg == ST_EMIT);
  assign at_last  = emitting && (k_reg == 3'd7);
  // A start is taken from idle or in the last-pixel cycle, which chains
  // groups without a bubble; a start mid-group is dropped.
  assign accept   = render_start && (!emitting || at_last);
  assign advance  = emitting && !at_last;
  assign fire     = accept || advance;

  // The pixel being registered this edge comes either from the live inputs
  // (pixel 0 of a newly accepted group) or from the latched group.
  always_comb begin
    src_idx    = idx_reg;
    src_data   = data_reg;
    src_sprite = sprite_reg;
    src_hflip  = hflip_reg;
    src_pal    = pal_reg;
    src_prio   = prio_reg;
    src_k      = k_reg + 3'd1;
    if (accept) begin
      src_idx    = render_idx;
      src_data   = render_data;
      src_sprite = is_sprite;
      src_hflip  = hflip;
      src_pal    = palette;
      src_prio   = render_priority;
      src_k      = 3'd0;
    end
  end

  // hflip picks pixel 7-k, which for 3 bits is the bitwise inverse of k.
  assign nib_sel = src_hflip ? ~src_k : src_k;
  // Pixel n lives at bit offset (7-n)*4.
  assign color   = src_data[{~nib_sel, 2'b00} +: 4];
  assign col     = src_idx + {6'd0, src_k};
  assign visible = ({1'b0, col} < VIS_W);

  always_comb begin
    tprio_at = 1'b0;
    socc_at  = 1'b0;
    if (visible) begin
      tprio_at = tprio[col];
      socc_at  = socc[col];
    end
  end

  always_comb begin
    write = 1'b0;
    if (visible) begin
      if (!src_sprite)
        write = 1'b1;
      else
        write = (color != 4'd0) && !socc_at && (src_prio || !tprio_at);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= ST_IDLE;
      k_reg      <= 3'd0;
      idx_reg    <= 9'd0;
      data_reg   <= 32'd0;
      sprite_reg <= 1'b0;
      hflip_reg  <= 1'b0;
      pal_reg    <= 2'd0;
      prio_reg   <= 1'b0;
      wridx_reg  <= 9'd0;
      wrdata_reg <= 6'd0;
      wren_reg   <= 1'b0;
    end else if (fire) begin
      state_reg  <= ST_EMIT;
      k_reg      <= src_k;
      wridx_reg  <= col;
      wrdata_reg <= {src_pal, color};
      wren_reg   <= write;
      if (accept) begin
        idx_reg    <= render_idx;
        data_reg   <= render_data;
        sprite_reg <= is_sprite;
        hflip_reg  <= hflip;
        pal_reg    <= palette;
        prio_reg   <= render_priority;
      end
    end else begin
      state_reg <= ST_IDLE;
      k_reg     <= 3'd0;
      wren_reg  <= 1'b0;
    end
  end

  // Mask updates land on the same edge as the pixel, so the next pixel
  // (including one of a chained, overlapping sprite) already sees them.
  always_ff @(posedge clk) begin
    if (reset && fire && visible) begin
      if (!src_sprite) begin
        tprio[col] <= src_prio && (color != 4'd0);
        socc[col]  <= 1'b0;
      end else if (write) begin
        socc[col] <= 1'b1;
      end
    end
  end

  assign busy       = emitting;
  assign last_pixel = at_last;
  assign wridx      = wridx_reg;
  assign wrdata     = wrdata_reg;
  assign wren       = wren_reg;

endmodule

// File: tb/tb_gfx_renderer.sv
// Self-checking bench for gfx_renderer: directed pattern groups with
// hand-computed expected write streams, one task per scenario.
module tb_gfx_renderer;

  logic        clk;
  logic        reset;
  logic [8:0]  render_idx;
  logic [31:0] render_data;
  logic        render_start;
  logic        is_sprite;
  logic        hflip;
  logic [1:0]  palette;
  logic        render_priority;
  logic        last_pixel;
  logic        busy;
  logic [8:0]  wridx;
  logic [5:0]  wrdata;
  logic        wren;

  int pass_cnt;
  int total_cnt;

  gfx_renderer #(.VISIBLE_W(320)) dut (
    .clk             (clk),
    .reset           (reset),
    .render_idx      (render_idx),
    .render_data     (render_data),
    .render_start    (render_start),
    .is_sprite       (is_sprite),
    .hflip           (hflip),
    .palette         (palette),
    .render_priority (render_priority),
    .last_pixel      (last_pixel),
    .busy            (busy),
    .wridx           (wridx),
    .wrdata          (wrdata),
    .wren            (wren)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one start strobe; caller is positioned just after a rising edge.
  task automatic start_group(input logic [8:0] idx, input logic [31:0] data,
                             input logic spr, input logic hf,
                             input logic [1:0] pal, input logic prio);
    render_idx      = idx;
    render_data     = data;
    is_sprite       = spr;
    hflip           = hf;
    palette         = pal;
    render_priority = prio;
    render_start    = 1'b1;
  endtask

  // Runs a group to completion without checking (mask preparation).
  task automatic run_group(input logic [8:0] idx, input logic [31:0] data,
                           input logic spr, input logic [1:0] pal, input logic prio);
    start_group(idx, data, spr, 1'b0, pal, prio);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      render_start = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    render_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({busy, last_pixel, wren, wridx, wrdata} !== 18'd0)
      $display("FAIL reset: busy=%b last=%b wren=%b wridx=%0d wrdata=%h required all 0",
               busy, last_pixel, wren, wridx, wrdata);
    else pass_cnt++;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_tile;
    logic [8:0] exp_idx;
    logic [5:0] exp_data;
    start_group(9'd0, 32'h0123_4567, 1'b0, 1'b0, 2'd2, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      render_start = 1'b0;
      exp_idx  = 9'(i);
      exp_data = 6'h20 + 6'(i);
      total_cnt++;
      if ({busy, last_pixel, wren, wridx, wrdata} !== {1'b1, (i == 7), 1'b1, exp_idx, exp_data})
        $display("FAIL tile k=%0d: busy=%b last=%b wren=%b wridx=%0d wrdata=%h required 1 %b 1 %0d %h",
                 i, busy, last_pixel, wren, wridx, wrdata, (i == 7), exp_idx, exp_data);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    total_cnt++;
    if ({busy, last_pixel, wren} !== 3'b000)
      $display("FAIL tile_idle: busy=%b last=%b wren=%b required 000", busy, last_pixel, wren);
    else pass_cnt++;
  endtask

  task automatic test_hflip_wrap;
    logic [8:0] exp_idx;
    start_group(9'd505, 32'h0123_4567, 1'b0, 1'b1, 2'd2, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      render_start = 1'b0;
      exp_idx = 9'd505 + 9'(i);
      total_cnt++;
      if ({busy, wren, wridx} !== {1'b1, (i == 7), exp_idx})
        $display("FAIL hflip_wrap k=%0d: busy=%b wren=%b wridx=%0d required 1 %b %0d",
                 i, busy, wren, wridx, (i == 7), exp_idx);
      else pass_cnt++;
      if (i == 7) begin
        total_cnt++;
        if (wrdata !== 6'h20)
          $display("FAIL hflip_data: wrdata=%h required 20", wrdata);
        else pass_cnt++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_tile_priority;
    run_group(9'd0, 32'h1234_5678, 1'b0, 2'd0, 1'b1);
    // Low-priority sprite behind priority tiles: nothing written.
    start_group(9'd0, 32'hF0F0_F0F0, 1'b1, 1'b0, 2'd1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      render_start = 1'b0;
      total_cnt++;
      if ({busy, wren, wridx} !== {1'b1, 1'b0, 9'(i)})
        $display("FAIL sprite_behind k=%0d: busy=%b wren=%b wridx=%0d required 1 0 %0d",
                 i, busy, wren, wridx, i);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    // High-priority sprite: opaque pixels at even columns only.
    start_group(9'd0, 32'hF0F0_F0F0, 1'b1, 1'b0, 2'd1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      render_start = 1'b0;
      total_cnt++;
      if ({busy, wren, wridx} !== {1'b1, (i % 2 == 0), 9'(i)})
        $display("FAIL sprite_front k=%0d: busy=%b wren=%b wridx=%0d required 1 %b %0d",
                 i, busy, wren, wridx, (i % 2 == 0), i);
      else pass_cnt++;
      if (i % 2 == 0) begin
        total_cnt++;
        if (wrdata !== 6'h1F)
          $display("FAIL sprite_front_data k=%0d: wrdata=%h required 1f", i, wrdata);
        else pass_cnt++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [8:0] exp_idx;
    logic       exp_wren;
    run_group(9'd8, 32'h0, 1'b0, 2'd0, 1'b0);
    run_group(9'd16, 32'h0, 1'b0, 2'd0, 1'b0);
    start_group(9'd10, 32'hFFFF_FFFF, 1'b1, 1'b0, 2'd1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      render_start = 1'b0;
      if (i < 8) begin
        exp_idx  = 9'd10 + 9'(i);
        exp_wren = 1'b1;
      end else begin
        exp_idx  = 9'd12 + 9'(i - 8);
        exp_wren = (exp_idx >= 9'd18);
      end
      total_cnt++;
      if ({busy, last_pixel, wren, wridx} !== {1'b1, (i == 7 || i == 15), exp_wren, exp_idx})
        $display("FAIL b2b i=%0d: busy=%b last=%b wren=%b wridx=%0d required 1 %b %b %0d",
                 i, busy, last_pixel, wren, wridx, (i == 7 || i == 15), exp_wren, exp_idx);
      else pass_cnt++;
      if (exp_wren) begin
        total_cnt++;
        if (wrdata !== ((i < 8) ? 6'h1F : 6'h33))
          $display("FAIL b2b_data i=%0d: wrdata=%h required %h", i, wrdata,
                   (i < 8) ? 6'h1F : 6'h33);
        else pass_cnt++;
      end
      if (i == 7) start_group(9'd12, 32'h3333_3333, 1'b1, 1'b0, 2'd3, 1'b1);
    end
    @(posedge clk); #1;
    total_cnt++;
    if ({busy, wren} !== 2'b00)
      $display("FAIL b2b_idle: busy=%b wren=%b required 00", busy, wren);
    else pass_cnt++;
  endtask

  task automatic test_ignored_start;
    logic [8:0] exp_idx;
    logic [5:0] exp_data;
    start_group(9'd100, 32'h89AB_CDEF, 1'b0, 1'b0, 2'd1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      render_start = 1'b0;
      exp_idx  = 9'd100 + 9'(i);
      exp_data = 6'h18 + 6'(i);
      total_cnt++;
      if ({busy, wren, wridx, wrdata} !== {1'b1, 1'b1, exp_idx, exp_data})
        $display("FAIL ignored_start k=%0d: busy=%b wren=%b wridx=%0d wrdata=%h required 1 1 %0d %h",
                 i, busy, wren, wridx, wrdata, exp_idx, exp_data);
      else pass_cnt++;
      if (i == 3) start_group(9'd300, 32'h1111_1111, 1'b1, 1'b1, 2'd3, 1'b1);
    end
    @(posedge clk); #1;
    total_cnt++;
    if ({busy, wren} !== 2'b00)
      $display("FAIL ignored_idle: busy=%b wren=%b required 00", busy, wren);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_group;
    start_group(9'd200, 32'h1234_5678, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      render_start = 1'b0;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if ({busy, last_pixel, wren, wridx} !== 12'd0)
      $display("FAIL reset_mid: busy=%b last=%b wren=%b wridx=%0d required 0 0 0 0",
               busy, last_pixel, wren, wridx);
    else pass_cnt++;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if ({busy, wren} !== 2'b00)
        $display("FAIL reset_no_write c=%0d: busy=%b wren=%b required 00", i, busy, wren);
      else pass_cnt++;
    end
    test_tile();
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    render_idx = '0;
    render_data = '0;
    is_sprite = 1'b0;
    hflip = 1'b0;
    palette = '0;
    render_priority = 1'b0;
    render_start = 1'b0;
    reset = 1'b0;
    test_reset();
    test_tile();
    test_hflip_wrap();
    test_tile_priority();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid_group();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
